// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath: one state per fetch, decode,
// execute, memory and write-back step, with a memory-ready watchdog, a sticky
// error trap and a retired-instruction counter.
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       Op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic [3:0]       state_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] instret_o
);

  // MAX_WAIT = 0 still needs a one-bit counter that only ever holds zero.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12,
    ERROR  = 4'd15
  } stateT;

  stateT             state, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic [1:0]        errCode, errCodeNext;
  logic [CNT_W-1:0]  instret;
  logic              memWait;
  logic              retire;
  logic              enterMem;

  // Next-state selection, including opcode decode and the watchdog trap.
  always_comb begin
    nextState   = state;
    errCodeNext = errCode;
    case (state)
      IDLE:   if (start_i) nextState = FETCH;
      FETCH:  if (mem_ready_i) nextState = DECODE;
      DECODE: begin
        case (Op_i)
          OP_RTYPE:     nextState = EXEC;
          OP_ADDI:      nextState = ADDIEX;
          OP_LW, OP_SW: nextState = MEMADR;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default: begin
            nextState   = ERROR;
            errCodeNext = 2'b01;
          end
        endcase
      end
      MEMADR: nextState = (Op_i == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready_i) nextState = MEMWB;
      MEMWB:  nextState = FETCH;
      MEMWR:  if (mem_ready_i) nextState = FETCH;
      EXEC:   nextState = RWB;
      RWB:    nextState = FETCH;
      BRANCH: nextState = FETCH;
      JUMP:   nextState = FETCH;
      ADDIEX: nextState = ADDIWB;
      ADDIWB: nextState = FETCH;
      ERROR:  nextState = ERROR;
      default: nextState = IDLE;
    endcase
    // Watchdog overrides the normal stall-in-place behaviour.
    if (memWait && !mem_ready_i && (waitCnt == WAIT_LIMIT)) begin
      nextState   = ERROR;
      errCodeNext = 2'b10;
    end
  end

  // Qualifiers for the watchdog and retirement counter.
  always_comb begin
    memWait  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    enterMem = (nextState != state) &&
               ((nextState == FETCH) || (nextState == MEMRD) || (nextState == MEMWR));
    retire   = (nextState == FETCH) &&
               (state inside {MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB});
  end

  // State, watchdog, error cause and retirement count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      waitCnt <= '0;
      errCode <= '0;
      instret <= '0;
    end else begin
      state   <= nextState;
      errCode <= errCodeNext;
      if (enterMem)
        waitCnt <= '0;
      else if (memWait && !mem_ready_i && (waitCnt != WAIT_LIMIT))
        waitCnt <= waitCnt + WAIT_W'(1);
      if (retire)
        instret <= instret + CNT_W'(1);
    end
  end

  // Per-state datapath controls; only PCWrite/IRWrite in FETCH see mem_ready_i.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    PCSource_o    = 2'b00;
    case (state)
      FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        PCWrite_o = mem_ready_i;
        IRWrite_o = mem_ready_i;
      end
      DECODE: ALUSrcB_o = 2'b11;
      MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
      end
      RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
      end
      JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      ADDIWB: RegWrite_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o    = state;
  assign err_o      = (state == ERROR);
  assign err_code_o = errCode;
  assign instret_o  = instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed program table, hand-written corner
// sequences, and a randomized run against an instruction-path reference model.
module tb_multicycle_control;

  localparam int MAXW_A = 15;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [5:0] op;

  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic aPcw, aPcc, aIord, aMr, aMw, aIrw, aM2r, aRd, aRw, aAsa, aErr;
  logic [1:0] aAsb, aAop, aPcs, aCode;
  logic [3:0] aState;
  logic [31:0] aRet;
  logic [15:0] aCtrl;
  assign aCtrl = {aPcw, aPcc, aIord, aMr, aMw, aIrw, aM2r, aRd, aRw, aAsa, aAsb, aAop, aPcs};

  multicycle_control #(.MAX_WAIT(MAXW_A), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .mem_ready_i(ready),
    .PCWrite_o(aPcw), .PCWriteCond_o(aPcc), .IorD_o(aIord), .MemRead_o(aMr),
    .MemWrite_o(aMw), .IRWrite_o(aIrw), .MemtoReg_o(aM2r), .RegDst_o(aRd),
    .RegWrite_o(aRw), .ALUSrcA_o(aAsa), .ALUSrcB_o(aAsb), .ALUOp_o(aAop),
    .PCSource_o(aPcs), .state_o(aState), .err_o(aErr), .err_code_o(aCode),
    .instret_o(aRet)
  );

  // Instance S: short watchdog and narrow counter, same inputs.
  logic sPcw, sPcc, sIord, sMr, sMw, sIrw, sM2r, sRd, sRw, sAsa, sErr;
  logic [1:0] sAsb, sAop, sPcs, sCode, sRet;
  logic [3:0] sState;

  multicycle_control #(.MAX_WAIT(2), .CNT_W(2)) dutS (
    .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .mem_ready_i(ready),
    .PCWrite_o(sPcw), .PCWriteCond_o(sPcc), .IorD_o(sIord), .MemRead_o(sMr),
    .MemWrite_o(sMw), .IRWrite_o(sIrw), .MemtoReg_o(sM2r), .RegDst_o(sRd),
    .RegWrite_o(sRw), .ALUSrcA_o(sAsa), .ALUSrcB_o(sAsb), .ALUOp_o(sAop),
    .PCSource_o(sPcs), .state_o(sState), .err_o(sErr), .err_code_o(sCode),
    .instret_o(sRet)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input bit pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                     input bit [1:0] asb, aop, pcs);
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  // Expected control word for a state number, straight from the control table.
  function automatic logic [15:0] ctrlOf(input int st, input bit rdy);
    case (st)
      1:  return mk(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      2:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      3:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      4:  return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      5:  return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      6:  return mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      7:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
      8:  return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      9:  return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
      10: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
      11: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      12: return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model: an instruction is FETCH, DECODE, then a per-opcode path.
  int          mSt, mWait, mCode, pIdx;
  int unsigned mRet;
  int          path[$];

  task automatic setPath(input logic [5:0] o);
    path.delete();
    case (o)
      6'h00: path = '{7, 8};
      6'h08: path = '{11, 12};
      6'h23: path = '{3, 4, 5};
      6'h2B: path = '{3, 6};
      6'h04: path = '{9};
      6'h02: path = '{10};
      default: ;
    endcase
  endtask

  task automatic enter(input int s);
    mSt   = s;
    mWait = 0;
  endtask

  task automatic modelStep(input bit r, input bit s, input logic [5:0] o, input bit rdy);
    if (r) begin
      mSt = 0; mWait = 0; mCode = 0; mRet = 0;
    end else if (mSt == 0) begin
      if (s) enter(1);
    end else if (mSt == 15) begin
      mSt = 15;
    end else if (mSt == 2) begin
      setPath(o);
      if (path.size() == 0) begin
        mSt = 15; mCode = 1;
      end else begin
        pIdx = 0;
        enter(path[0]);
      end
    end else if ((mSt == 1 || mSt == 4 || mSt == 6) && !rdy) begin
      if (mWait == MAXW_A) begin
        mSt = 15; mCode = 2;
      end else mWait++;
    end else if (mSt == 1) begin
      enter(2);
    end else begin
      pIdx++;
      if (pIdx < path.size()) enter(path[pIdx]);
      else begin
        mRet++;
        enter(1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; op = 6'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] op;
    int         st;
    int         ret;
  } vecT;

  vecT prog[23];
  logic [5:0] legal[6];

  initial begin
    prog = '{
      '{6'h00, 1, 0}, '{6'h00, 2, 0}, '{6'h00, 7, 0}, '{6'h00, 8, 0},
      '{6'h08, 1, 1}, '{6'h08, 2, 1}, '{6'h08, 11, 1}, '{6'h08, 12, 1},
      '{6'h23, 1, 2}, '{6'h23, 2, 2}, '{6'h23, 3, 2}, '{6'h23, 4, 2}, '{6'h23, 5, 2},
      '{6'h2B, 1, 3}, '{6'h2B, 2, 3}, '{6'h2B, 3, 3}, '{6'h2B, 6, 3},
      '{6'h04, 1, 4}, '{6'h04, 2, 4}, '{6'h04, 9, 4},
      '{6'h02, 1, 5}, '{6'h02, 2, 5}, '{6'h02, 10, 5}
    };
    legal = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

    // Reset, then start with memory ready.
    doReset();
    #1;
    chk("reset state", aState, 0);
    chk("reset ctrl", aCtrl, 0);
    chk("reset instret", aRet, 0);
    chk("reset err", {aErr, aCode}, 0);
    start = 1'b1; ready = 1'b1;
    #1;
    chk("idle ctrl", aCtrl, 0);
    tick();
    start = 1'b0;

    // Zero-wait program from the table.
    for (int i = 0; i < 23; i++) begin
      op = prog[i].op;
      #1;
      chk($sformatf("prog[%0d] state", i), aState, prog[i].st);
      chk($sformatf("prog[%0d] ctrl", i), aCtrl, ctrlOf(prog[i].st, 1'b1));
      chk($sformatf("prog[%0d] instret", i), aRet, prog[i].ret);
      tick();
    end
    #1;
    chk("prog end state", aState, 1);
    chk("prog end instret", aRet, 6);

    // lw with three stall cycles in MEMRD.
    doReset();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; op = 6'h23;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      #1;
      chk($sformatf("stall[%0d] state", k), aState, 4);
      chk($sformatf("stall[%0d] MemRead/IorD", k), {aMr, aIord}, 2'b11);
      tick();
    end
    #1;
    chk("stall then MEMWB", aState, 5);
    chk("stall no error", aErr, 0);

    // Short watchdog: ready on the last allowed MEMRD cycle completes normally.
    doReset();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; op = 6'h23;
    tick(); tick(); tick();
    ready = 1'b0;
    tick(); tick();
    ready = 1'b1;
    #1;
    chk("limit MEMRD state", sState, 4);
    tick();
    #1;
    chk("limit then MEMWB", sState, 5);
    chk("limit no error", sErr, 0);

    // Short watchdog timeout in FETCH.
    doReset();
    start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("tmo fetch[%0d] state", k), sState, 1);
      chk($sformatf("tmo fetch[%0d] PCWrite", k), sPcw, 0);
      tick();
    end
    #1;
    chk("tmo state", sState, 15);
    chk("tmo err", sErr, 1);
    chk("tmo code", sCode, 2'b10);
    start = 1'b1;
    tick(); tick();
    #1;
    chk("tmo sticky state", sState, 15);
    chk("tmo sticky code", sCode, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("tmo reset state", sState, 0);
    chk("tmo reset err", {sErr, sCode}, 0);
    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst beats start", aState, 0);

    // Illegal opcode after one retired jump.
    doReset();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; op = 6'h02;
    tick(); tick(); tick();
    op = 6'h3F;
    tick();
    #1;
    chk("illegal decode state", aState, 2);
    tick();
    #1;
    chk("illegal state", aState, 15);
    chk("illegal code", aCode, 2'b01);
    chk("illegal instret", aRet, 1);
    chk("illegal ctrl", aCtrl, 0);
    chk("illegal err", aErr, 1);

    // Reset in the middle of a stalled store.
    doReset();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; op = 6'h02;
    tick(); tick(); tick();
    op = 6'h2B;
    tick(); tick(); tick();
    ready = 1'b0;
    #1;
    chk("memwr state", aState, 6);
    chk("memwr MemWrite", aMw, 1);
    chk("memwr instret", aRet, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("memwr reset state", aState, 0);
    chk("memwr reset MemWrite", aMw, 0);
    chk("memwr reset instret", aRet, 0);

    // Counter wrap: five jumps on a 2-bit counter.
    doReset();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; op = 6'h02;
    for (int k = 0; k < 5; k++) begin
      tick(); tick(); tick();
    end
    #1;
    chk("wrap narrow instret", sRet, 1);
    chk("wrap wide instret", aRet, 5);

    // Randomized run against the reference model.
    doReset();
    modelStep(1'b1, 1'b0, 6'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      start = $urandom_range(0, 1);
      ready = ($urandom_range(0, 9) < 7);
      if (mSt == 0 || mSt == 1) begin
        if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
        else op = legal[$urandom_range(0, 5)];
      end
      #1;
      chk("rand state", aState, mSt);
      chk("rand ctrl", aCtrl, ctrlOf(mSt, ready));
      chk("rand err", {aErr, aCode}, {(mSt == 15), 2'(mCode)});
      chk("rand instret", aRet, mRet);
      @(posedge clk);
      modelStep(rst, start, op, ready);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath. It supports R-type, addi, lw, sw, beq and j. Fetch, decode, execute, memory and write-back each take their own cycle, so one shared ALU and one shared memory serve all of them. Memory accesses wait on a ready handshake guarded by a watchdog. Illegal opcodes and memory timeouts trap into a sticky error state. A retired-instruction counter is provided for performance checks.

## Interface
- MAX_WAIT, 15: maximum stall cycles tolerated per memory access (0 = memory must be ready in the first cycle).
- CNT_W, 32: width of the retired-instruction counter.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- start_i  in  1  leaves IDLE and begins fetching.
- Op_i  in  6  opcode from IR[31:26]; sampled only in DECODE and MEMADR.
- mem_ready_i  in  1  memory completes the current access this cycle.
- PCWrite_o  out  1  unconditional PC write.
- PCWriteCond_o  out  1  PC write if ALU zero.
- IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead_o  out  1  memory read.
- MemWrite_o  out  1  memory write.
- IRWrite_o  out  1  instruction register load.
- MemtoReg_o  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- RegDst_o  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite_o  out  1  register file write.
- ALUSrcA_o  out  1  ALU A: 0 = PC, 1 = rs.
- ALUSrcB_o  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_o  out  4  current state encoding.
- err_o  out  1  high in ERROR.
- err_code_o  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none.
- instret_o  out  CNT_W  retired-instruction count.

## Operation
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6.
  - EXEC = 7, RWB = 8, BRANCH = 9, JUMP = 10, ADDIEX = 11, ADDIWB = 12, ERROR = 15.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Goes to FETCH when start_i = 1.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - PCWrite and IRWrite = mem_ready_i. These two are the only Mealy outputs.
  - Goes to DECODE on mem_ready_i.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by Op_i:
  - 000000 → EXEC
  - 001000 → ADDIEX
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → ERROR with code 01
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead = 1, IorD = 1. Goes to MEMWB on mem_ready_i.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Goes to FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Goes to FETCH on mem_ready_i.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Goes to RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Goes to FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Goes to FETCH.
- ERROR: all control outputs 0; err_o = 1; err_code_o holds the cause. Sticky until rst_i; start_i is ignored.
- Watchdog:
  - Counter width is clog2(MAX_WAIT + 1); it is cleared on every transition into FETCH, MEMRD or MEMWR.
  - In those three states, the counter increments each cycle that mem_ready_i = 0.
  - If mem_ready_i = 0 while counter == MAX_WAIT, the next state is ERROR with code 10.
- Retirement counter:
  - instret_o increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
  - It wraps modulo 2^CNT_W.
  - It is not incremented on entry to FETCH from IDLE or on entry to ERROR.

## Timing
- Reset: on any edge with rst_i = 1, the block returns to IDLE and clears the watchdog counter, instret_o, err_o and err_code_o. This applies in every state, including mid-access and ERROR.
- All outputs are 0 in the cycle after reset, since IDLE drives everything low.
- Rule: outputs reflect the current state, and transitions take effect on the next edge.
- Zero-wait latency in cycles, counted from the first FETCH cycle:

| Instruction | Cycles | States |
|---|---|---|
| lw | 5 | F, D, MA, MR, WB |
| sw | 4 | F, D, MA, MW |
| R-type | 4 | F, D, EX, RWB |
| addi | 4 | F, D, ADDIEX, ADDIWB |
| beq | 3 | F, D, BR |
| j | 3 | F, D, J |

- Each stall cycle in FETCH, MEMRD or MEMWR adds one cycle.
- A memory state lasts at most MAX_WAIT + 1 cycles. mem_ready_i = 1 on cycle MAX_WAIT + 1 completes the access normally.
- rst_i and start_i high together: reset wins.

## Test plan
- Reset then start: rst_i for 2 cycles, then start_i = 1 with mem_ready_i = 1.
  - Required: state_o goes 0 → 1; PCWrite = IRWrite = 1 in FETCH; instret_o = 0.
- Zero-wait program, mem_ready_i tied to 1, opcodes 000000, 001000, 100011, 101011, 000100, 000010.
  - Required: state sequence 1,2,7,8, 1,2,11,12, 1,2,3,4,5, 1,2,3,6, 1,2,9, 1,2,10.
  - Required: instret_o = 6 after 23 cycles; every output per state matches Operation.
- Stall: lw with mem_ready_i = 0 for 3 cycles in MEMRD, MAX_WAIT = 15.
  - Required: MemRead = IorD = 1 held for 4 cycles; MEMWB follows; no error.
- Timeout: MAX_WAIT = 2, mem_ready_i stuck at 0 in FETCH.
  - Required: 3 FETCH cycles with PCWrite = 0, then state_o = 15, err_o = 1, err_code_o = 10.
  - Required: start_i then has no effect; rst_i returns to IDLE.
- Illegal opcode 111111 in DECODE.
  - Required: state_o = 15 next cycle, err_code_o = 01, instret_o unchanged, all controls 0.
- Reset mid-MEMWR with MemWrite = 1.
  - Required: next cycle state_o = 0, MemWrite = 0, instret_o = 0.
- Wrap: CNT_W = 2, five j instructions.
  - Required: instret_o = 1.
